systolic_gemm_engine: RTL
=========================

SYSTOLIC_GEMM_ENGINE -- requirements
Module: systolic_gemm_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: signed weight/activation width.
REQ-002 SHALL have parameter ROWS, default 4: PE rows, which is also the dot-product length K.
REQ-003 SHALL have parameter COLS, default 4: PE columns, which is also the output vector length N.
REQ-004 SHALL have parameter ACCUM_WIDTH, default 32: signed partial-sum width.
REQ-005 SHALL provide port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL provide w_valid in 1 / w_ready out 1 / w_data in COLS*DATA_WIDTH: one weight row per beat, column c at bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL provide a_valid in 1 / a_ready out 1 / a_data in ROWS*DATA_WIDTH: one activation vector per beat, element r at the same slicing.
REQ-009 SHALL provide o_valid out 1 / o_ready in 1 / o_data out COLS*ACCUM_WIDTH: one deskewed result vector per beat.
REQ-010 SHALL provide busy, output, 1 bit: high when state is not LOAD or when any result is in flight.

Function
REQ-011 SHALL transfer data on any interface only in a cycle where valid && ready.
REQ-012 SHALL implement FSM states LOAD, RUN, DRAIN; the reset state is LOAD.
REQ-013 LOAD: w_ready=1 and a_ready=0; beat k writes weight row k (k = 0..ROWS-1); after beat ROWS-1 -> RUN; row counter wraps to 0.
REQ-014 RUN: a_ready = !w_valid && advance; the accepted vector x yields o_data[c] = sum over r of W[r][c]*x[r].
REQ-015 RUN with w_valid=1 -> DRAIN; activations are no longer accepted from that cycle on.
REQ-016 DRAIN: a_ready=0 and w_ready=0; when the in-flight count is 0 -> LOAD; in-flight results complete with the old weights.
REQ-017 advance = !(o_valid && !o_ready); when advance=0, all PE, skew, deskew and valid-pipeline registers SHALL hold.
REQ-018 latency SHALL be exactly ROWS+COLS advancing cycles from a_valid&&a_ready to the matching o_valid; results are returned in order; throughput is 1 vector/cycle.
REQ-019 input skew: row r activation delayed r cycles; output deskew: column c delayed COLS-1-c cycles; a 1-bit valid token travels with each vector.
REQ-020 in-flight counter: +1 on accept, -1 on o_valid&&o_ready, unchanged on simultaneous accept and output; width $clog2(ROWS+COLS+2).
REQ-021 product is full 2*DATA_WIDTH signed, then sign-extended to ACCUM_WIDTH; the row-0 PE adds to 0.
REQ-022 o_data and o_valid SHALL be registered outputs; o_data is stable while o_valid && !o_ready.

Reset
REQ-023 rst SHALL clear: state=LOAD, row counter=0, weights=0, all pipeline/skew/valid registers=0, o_valid=0, o_data=0, in-flight=0.
REQ-024 rst asserted mid-operation SHALL discard in-flight results; o_valid=0 in the cycle after rst is sampled high.
REQ-025 while rst is high: w_ready=0, a_ready=0, busy=0.

Configuration
REQ-026 with macro SYSTOLIC_SATURATE_EN defined, each PE addition SHALL saturate to [-2^(ACCUM_WIDTH-1), 2^(ACCUM_WIDTH-1)-1].
REQ-027 without SYSTOLIC_SATURATE_EN, additions SHALL wrap modulo 2^ACCUM_WIDTH, with no extra logic.

Structure
REQ-028 package systolic_pkg SHALL hold the FSM state enum typedef and the latency constant function (ROWS+COLS).
REQ-029 one sub-module ws_pe (stationary weight register, activation pass-right, psum pass-down, hold on !advance) SHALL be instantiated ROWS*COLS times via generate.

Verification
REQ-030 reset, load identity 4x4, send a=[1,2,3,4] -> o_data=[1,2,3,4] with o_valid exactly 8 cycles after acceptance.
REQ-031 W[r][c]=r+c, send 4 back-to-back vectors [1,1,1,1],[1,0,0,0],[0,0,0,2],[2,2,2,2] -> 4 consecutive beats [6,10,14,18],[0,1,2,3],[6,8,10,12],[12,20,28,36].
REQ-032 o_ready low 5 cycles with 3 results in flight -> o_data stable throughout, a_ready=0, no loss or duplication, order preserved after release.
REQ-033 w_valid raised in RUN with 3 vectors in flight -> a_ready drops immediately, 3 results use the old weights, then LOAD and w_ready=1.
REQ-034 ACCUM_WIDTH=16, all W=127, all a=-128 -> o_data[c] = -32768 with SYSTOLIC_SATURATE_EN, and 512 without it.
REQ-035 rst pulsed while 2 results in flight -> o_valid=0 in the next cycle, busy=0, w_ready=1 after release, with no stale output appearing.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the weight-stationary systolic GEMM engine.
package systolic_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } gemm_state_t;

    // Advancing cycles from activation accept to the matching o_valid.
    function automatic int gemm_latency(input int rows, input int cols);
        return rows + cols;
    endfunction

endpackage

// File: rtl/ws_pe.sv
// Weight-stationary processing element: holds one weight, passes the
// activation right and the partial sum down, and freezes on !advance.
// Build option: SYSTOLIC_SATURATE_EN makes the accumulate saturate instead of wrap.
module ws_pe #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACCUM_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          advance,
    input  logic                          w_we,
    input  logic signed [DATA_WIDTH-1:0]  w_in,
    input  logic signed [DATA_WIDTH-1:0]  a_in,
    input  logic signed [ACCUM_WIDTH-1:0] psum_in,
    output logic signed [DATA_WIDTH-1:0]  a_out,
    output logic signed [ACCUM_WIDTH-1:0] psum_out
);

    logic signed [DATA_WIDTH-1:0]   w_q;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACCUM_WIDTH-1:0]  prod_ext;
    logic signed [ACCUM_WIDTH-1:0]  sum;

    assign prod     = a_in * w_q;
    assign prod_ext = ACCUM_WIDTH'(prod);

`ifdef SYSTOLIC_SATURATE_EN
    logic signed [ACCUM_WIDTH:0] wide;

    assign wide = {psum_in[ACCUM_WIDTH-1], psum_in} + {prod_ext[ACCUM_WIDTH-1], prod_ext};

    // Clamp to the signed accumulator range when the extra sign bit disagrees
    always_comb begin
        if (wide[ACCUM_WIDTH] != wide[ACCUM_WIDTH-1])
            sum = wide[ACCUM_WIDTH] ? {1'b1, {(ACCUM_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACCUM_WIDTH-1){1'b1}}};
        else
            sum = wide[ACCUM_WIDTH-1:0];
    end
`else
    assign sum = psum_in + prod_ext;
`endif

    // Stationary weight, written only during a load beat addressed to this row
    always_ff @(posedge clk) begin
        if (rst)
            w_q <= '0;
        else if (w_we)
            w_q <= w_in;
    end

    // Activation and partial-sum pipeline registers, held while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            a_out    <= '0;
            psum_out <= '0;
        end else if (advance) begin
            a_out    <= a_in;
            psum_out <= sum;
        end
    end

endmodule

// File: rtl/systolic_gemm_engine.sv
// Weight-stationary systolic GEMM engine: o[c] = sum_r W[r][c] * x[r].
// Build option: SYSTOLIC_SATURATE_EN (saturating PE accumulation, see ws_pe).
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  LOAD  | accept ROWS weight rows; activations blocked
//  RUN   | stream activation vectors; w_valid requests a reload
//  DRAIN | no new input; wait for in-flight results, then back to LOAD
module systolic_gemm_engine
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int ACCUM_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        w_valid,
    output logic                        w_ready,
    input  logic [COLS*DATA_WIDTH-1:0]  w_data,
    input  logic                        a_valid,
    output logic                        a_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]  a_data,
    output logic                        o_valid,
    input  logic                        o_ready,
    output logic [COLS*ACCUM_WIDTH-1:0] o_data,
    output logic                        busy
);

    localparam int LAT = gemm_latency(ROWS, COLS);
    localparam int CW  = $clog2(ROWS + COLS + 2);
    localparam int RCW = (ROWS > 1) ? $clog2(ROWS) : 1;

    gemm_state_t     state_q, state_d;
    logic [RCW-1:0]  row_q, row_d;
    logic [CW-1:0]   inflight_q;
    logic [LAT-2:0]  vpipe_q;
    logic            advance, a_acc, w_acc, o_acc;

    logic signed [DATA_WIDTH-1:0]  x_in    [ROWS];
    logic signed [DATA_WIDTH-1:0]  a_h     [ROWS][COLS+1];
    logic signed [ACCUM_WIDTH-1:0] p_v     [ROWS+1][COLS];
    logic signed [ACCUM_WIDTH-1:0] col_out [COLS];

    assign advance = !(o_valid && !o_ready);
    assign a_acc   = a_valid && a_ready;
    assign w_acc   = w_valid && w_ready;
    assign o_acc   = o_valid && o_ready;
    assign busy    = !rst && ((state_q != LOAD) || (inflight_q != '0));

    // Next-state, row counter and handshake readies
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        w_ready = 1'b0;
        a_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                LOAD: begin
                    w_ready = 1'b1;
                    if (w_valid) begin
                        if (row_q == RCW'(ROWS - 1)) begin
                            row_d   = '0;
                            state_d = RUN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    a_ready = !w_valid && advance;
                    if (w_valid)
                        state_d = DRAIN;
                end
                DRAIN: begin
                    if (inflight_q == '0)
                        state_d = LOAD;
                end
                default: state_d = LOAD;
            endcase
        end
    end

    // State and weight-row counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    // Count of accepted vectors whose result has not yet been taken
    always_ff @(posedge clk) begin
        if (rst)
            inflight_q <= '0;
        else begin
            case ({a_acc, o_acc})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Valid token shifting alongside each vector's data
    always_ff @(posedge clk) begin
        if (rst)
            vpipe_q <= '0;
        else if (advance) begin
            vpipe_q[0] <= a_acc;
            for (int i = 1; i < LAT - 1; i++)
                vpipe_q[i] <= vpipe_q[i-1];
        end
    end

    // Zero the array inputs on cycles with no accepted vector
    always_comb begin
        for (int r = 0; r < ROWS; r++)
            x_in[r] = a_acc ? a_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        if (r == 0) begin : g_direct
            assign a_h[r][0] = x_in[r];
        end else begin : g_dly
            logic signed [DATA_WIDTH-1:0] sk [r];

            // Row r enters the array r cycles after acceptance
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < r; d++)
                        sk[d] <= '0;
                end else if (advance) begin
                    sk[0] <= x_in[r];
                    for (int d = 1; d < r; d++)
                        sk[d] <= sk[d-1];
                end
            end

            assign a_h[r][0] = sk[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_top
        assign p_v[0][c] = '0;
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            ws_pe #(
                .DATA_WIDTH  (DATA_WIDTH),
                .ACCUM_WIDTH (ACCUM_WIDTH)
            ) u_pe (
                .clk      (clk),
                .rst      (rst),
                .advance  (advance),
                .w_we     (w_acc && (row_q == RCW'(r))),
                .w_in     (w_data[c*DATA_WIDTH +: DATA_WIDTH]),
                .a_in     (a_h[r][c]),
                .psum_in  (p_v[r][c]),
                .a_out    (a_h[r][c+1]),
                .psum_out (p_v[r+1][c])
            );
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_dsk
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_direct
            assign col_out[c] = p_v[ROWS][c];
        end else begin : g_dly
            logic signed [ACCUM_WIDTH-1:0] dq [D];

            // Column c is delayed so all columns of a vector line up
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < D; d++)
                        dq[d] <= '0;
                end else if (advance) begin
                    dq[0] <= p_v[ROWS][c];
                    for (int d = 1; d < D; d++)
                        dq[d] <= dq[d-1];
                end
            end

            assign col_out[c] = dq[D-1];
        end
    end

    // Registered result stage; holds its beat until the sink takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (advance) begin
            o_valid <= vpipe_q[LAT-2];
            for (int c = 0; c < COLS; c++)
                o_data[c*ACCUM_WIDTH +: ACCUM_WIDTH] <= col_out[c];
        end
    end

endmodule
